// File: rtl/pkt_rx_crc.sv
// Ingress packet delimiter and CRC-8 checker that feeds a rewindable per-port FIFO.
// Good packets stay in the FIFO; bad or truncated packets are rewound out with fifo_flush.
//
// state   | meaning
// IDLE    | waiting for a header byte (in_sop); non-sop bytes are consumed and dropped
// PAYLOAD | receiving len payload bytes
// CRC     | next byte is the CRC and is compared with the running crc_r
module pkt_rx_crc #(
    parameter int CNT_WIDTH  = 16,
    parameter int DEST_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    input  logic                  in_sop,
    output logic                  in_ready,
    output logic [7:0]            fifo_data,
    output logic                  fifo_push,
    output logic                  fifo_pkt_start,
    output logic                  fifo_flush,
    input  logic                  fifo_full,
    output logic                  pkt_done,
    output logic                  pkt_ok,
    output logic [DEST_WIDTH-1:0] pkt_dest,
    output logic [CNT_WIDTH-1:0]  good_cnt,
    output logic [CNT_WIDTH-1:0]  bad_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CRC     = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                state, state_nxt;
    logic [7:0]            crc_r, crc_nxt;
    logic [5:0]            cnt, cnt_nxt;
    logic [5:0]            len_r, len_nxt;
    logic [DEST_WIDTH-1:0] dest_r, dest_nxt;
    logic                  accept;
    logic                  finish;
    logic                  finish_ok;

    // Poly 0x07, MSB first, one whole byte per call.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    assign fifo_data = in_data;
    assign accept    = in_valid && !fifo_full;

    always_comb begin
        state_nxt      = state;
        crc_nxt        = crc_r;
        cnt_nxt        = cnt;
        len_nxt        = len_r;
        dest_nxt       = dest_r;
        in_ready       = !fifo_full;
        fifo_push      = 1'b0;
        fifo_pkt_start = 1'b0;
        fifo_flush     = 1'b0;
        finish         = 1'b0;
        finish_ok      = 1'b0;

        case (state)
            IDLE: begin
                if (accept && in_sop) begin
                    fifo_push      = 1'b1;
                    fifo_pkt_start = 1'b1;
                    dest_nxt       = in_data[7 -: DEST_WIDTH];
                    len_nxt        = in_data[5:0];
                    crc_nxt        = crc8_next(8'h00, in_data);
                    cnt_nxt        = 6'd0;
                    state_nxt      = (in_data[5:0] != 6'd0) ? PAYLOAD : CRC;
                end
            end
            PAYLOAD, CRC: begin
                if (accept && in_sop) begin
                    // Truncated packet: hold the new header off for one cycle while rewinding.
                    in_ready   = 1'b0;
                    fifo_flush = 1'b1;
                    finish     = 1'b1;
                    state_nxt  = IDLE;
                end else if (accept && state == PAYLOAD) begin
                    fifo_push = 1'b1;
                    crc_nxt   = crc8_next(crc_r, in_data);
                    cnt_nxt   = cnt + 6'd1;
                    if (cnt + 6'd1 == len_r) begin
                        state_nxt = CRC;
                    end
                end else if (accept) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                    if (in_data == crc_r) begin
                        fifo_push = 1'b1;
                        finish_ok = 1'b1;
                    end else begin
                        fifo_flush = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            crc_r  <= 8'h00;
            cnt    <= 6'd0;
            len_r  <= 6'd0;
            dest_r <= '0;
        end else begin
            state  <= state_nxt;
            crc_r  <= crc_nxt;
            cnt    <= cnt_nxt;
            len_r  <= len_nxt;
            dest_r <= dest_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_done <= 1'b0;
            pkt_ok   <= 1'b0;
            pkt_dest <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else begin
            pkt_done <= finish;
            pkt_ok   <= finish_ok;
            if (finish) begin
                pkt_dest <= dest_r;
            end
            if (finish && finish_ok && good_cnt != '1) begin
                good_cnt <= good_cnt + CNT_ONE;
            end
            if (finish && !finish_ok && bad_cnt != '1) begin
                bad_cnt <= bad_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pkt_rx_crc.sv
// Bench for pkt_rx_crc: directed frames plus randomized packets, stalls and truncations,
// checked every cycle against a packet-level model; a second instance has 2-bit counters.
module tb_pkt_rx_crc;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_sop;
    logic       fifo_full;

    logic        in_ready, fifo_push, fifo_pkt_start, fifo_flush, pkt_done, pkt_ok;
    logic [7:0]  fifo_data;
    logic [1:0]  pkt_dest;
    logic [15:0] good_cnt, bad_cnt;

    logic       s_ready, s_push, s_start, s_flush, s_done, s_ok;
    logic [7:0] s_data;
    logic [1:0] s_dest;
    logic [1:0] s_good, s_bad;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    bit         m_in_pkt;
    byte_q_t    m_bytes;
    int         m_len;
    logic [1:0] m_pdest;
    logic       m_done, m_ok;
    logic [1:0] m_dest_out;
    int         m_good, m_bad;
    logic       m_accepted;
    logic       last_ready, last_push, last_start, last_flush;

    always #5 clk = ~clk;

    pkt_rx_crc #(.CNT_WIDTH(16), .DEST_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
        .in_ready(in_ready), .fifo_data(fifo_data), .fifo_push(fifo_push),
        .fifo_pkt_start(fifo_pkt_start), .fifo_flush(fifo_flush), .fifo_full(fifo_full),
        .pkt_done(pkt_done), .pkt_ok(pkt_ok), .pkt_dest(pkt_dest),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    pkt_rx_crc #(.CNT_WIDTH(2), .DEST_WIDTH(2)) dut_sat (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
        .in_ready(s_ready), .fifo_data(s_data), .fifo_push(s_push),
        .fifo_pkt_start(s_start), .fifo_flush(s_flush), .fifo_full(fifo_full),
        .pkt_done(s_done), .pkt_ok(s_ok), .pkt_dest(s_dest),
        .good_cnt(s_good), .bad_cnt(s_bad)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // CRC of the whole message treated as one MSB-first bit stream.
    function automatic logic [7:0] crc_of(input byte_q_t q);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ q[i][b];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    function automatic int sat(input int x, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (x > mx) ? mx : x;
    endfunction

    task automatic model_reset();
        m_in_pkt   = 1'b0;
        m_bytes.delete();
        m_len      = 0;
        m_pdest    = 2'd0;
        m_done     = 1'b0;
        m_ok       = 1'b0;
        m_dest_out = 2'd0;
        m_good     = 0;
        m_bad      = 0;
    endtask

    task automatic cycle(input logic v, input logic sop, input logic [7:0] d, input logic full);
        logic acc, e_ready, e_push, e_start, e_flush, n_done, n_ok;
        in_valid  = v;
        in_sop    = sop;
        in_data   = d;
        fifo_full = full;
        @(negedge clk);
        chk("pkt_done", pkt_done, m_done);
        chk("sat_pkt_done", s_done, m_done);
        if (m_done) begin
            chk("pkt_ok", pkt_ok, m_ok);
            chk("pkt_dest", pkt_dest, m_dest_out);
            chk("sat_pkt_ok", s_ok, m_ok);
        end
        chk("good_cnt", good_cnt, sat(m_good, 16));
        chk("bad_cnt", bad_cnt, sat(m_bad, 16));
        chk("sat_good_cnt", s_good, sat(m_good, 2));
        chk("sat_bad_cnt", s_bad, sat(m_bad, 2));

        acc = v && !full;
        e_ready = !full;
        e_push = 1'b0; e_start = 1'b0; e_flush = 1'b0; n_done = 1'b0; n_ok = 1'b0;
        if (!m_in_pkt) begin
            if (acc && sop) begin
                e_push = 1'b1; e_start = 1'b1;
                m_bytes.delete();
                m_bytes.push_back(d);
                m_len    = int'(d[5:0]);
                m_pdest  = d[7:6];
                m_in_pkt = 1'b1;
            end
        end else if (acc && sop) begin
            e_flush = 1'b1; e_ready = 1'b0; n_done = 1'b1;
            m_in_pkt = 1'b0;
            acc = 1'b0;
        end else if (acc) begin
            if (m_bytes.size() < m_len + 1) begin
                e_push = 1'b1;
                m_bytes.push_back(d);
            end else begin
                if (d == crc_of(m_bytes)) begin
                    e_push = 1'b1; n_ok = 1'b1;
                end else begin
                    e_flush = 1'b1;
                end
                n_done = 1'b1;
                m_in_pkt = 1'b0;
            end
        end

        chk("in_ready", in_ready, e_ready);
        chk("fifo_push", fifo_push, e_push);
        chk("fifo_pkt_start", fifo_pkt_start, e_start);
        chk("fifo_flush", fifo_flush, e_flush);
        chk("fifo_data", fifo_data, d);
        chk("sat_in_ready", s_ready, e_ready);
        chk("sat_fifo_push", s_push, e_push);
        chk("sat_pkt_start", s_start, e_start);
        chk("sat_fifo_flush", s_flush, e_flush);
        chk("sat_fifo_data", s_data, d);
        last_ready = in_ready; last_push = fifo_push;
        last_start = fifo_pkt_start; last_flush = fifo_flush;

        if (n_done) begin
            m_dest_out = m_pdest;
            if (n_ok) m_good++;
            else m_bad++;
        end
        m_done     = n_done;
        m_ok       = n_ok;
        m_accepted = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic sop, input logic [7:0] d);
        logic f;
        for (int k = 0; k < 200; k++) begin
            f = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) begin
                cycle(1'b0, 1'($urandom), 8'($urandom), f);
            end else begin
                cycle(1'b1, sop, d, f);
                if (m_accepted) return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout actual=not_accepted required=accepted data=%0h", d);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_data  = 8'h00;
        fifo_full = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        byte_q_t    pk;
        byte_q_t    q;
        logic [7:0] hdr, crc;
        logic [1:0] dst;
        int         ln, keep, ng;
        bit         trunc_prev;

        rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_data = 8'h00; fifo_full = 1'b0;
        model_reset();
        @(posedge clk);
        do_reset();
        chk("rst_pkt_done", pkt_done, 1'b0);
        chk("rst_pkt_ok", pkt_ok, 1'b0);
        chk("rst_pkt_dest", pkt_dest, 2'd0);
        chk("rst_good_cnt", good_cnt, 16'd0);
        chk("rst_bad_cnt", bad_cnt, 16'd0);

        q = {8'h40};
        chk("model_crc_40", crc_of(q), 8'hC7);
        q = {8'h01, 8'h00};
        chk("model_crc_0100", crc_of(q), 8'h15);

        // good zero-length packet to dest 1
        cycle(1'b1, 1'b1, 8'h40, 1'b0);
        chk("t1_start", last_start, 1'b1);
        chk("t1_push_hdr", last_push, 1'b1);
        cycle(1'b1, 1'b0, 8'hC7, 1'b0);
        chk("t1_push_crc", last_push, 1'b1);
        chk("t1_done", pkt_done, 1'b1);
        chk("t1_ok", pkt_ok, 1'b1);
        chk("t1_dest", pkt_dest, 2'd1);
        chk("t1_good", good_cnt, 16'd1);

        // bad CRC
        cycle(1'b1, 1'b1, 8'h40, 1'b0);
        cycle(1'b1, 1'b0, 8'hC6, 1'b0);
        chk("t2_flush", last_flush, 1'b1);
        chk("t2_no_push", last_push, 1'b0);
        chk("t2_ok", pkt_ok, 1'b0);
        chk("t2_bad", bad_cnt, 16'd1);

        // one-byte payload, then again with a stall before the payload byte
        cycle(1'b1, 1'b1, 8'h01, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h15, 1'b0);
        chk("t3_good", good_cnt, 16'd2);
        cycle(1'b1, 1'b1, 8'h01, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, 8'h00, 1'b1);
            chk("t3_stall_ready", last_ready, 1'b0);
            chk("t3_stall_push", last_push, 1'b0);
        end
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h15, 1'b0);
        chk("t3_stall_good", good_cnt, 16'd3);

        // truncation by a new header
        cycle(1'b1, 1'b1, 8'h03, 1'b0);
        cycle(1'b1, 1'b0, 8'hAA, 1'b0);
        cycle(1'b1, 1'b1, 8'h40, 1'b0);
        chk("t4_flush", last_flush, 1'b1);
        chk("t4_ready", last_ready, 1'b0);
        chk("t4_bad", bad_cnt, 16'd2);
        cycle(1'b1, 1'b1, 8'h40, 1'b0);
        chk("t4_restart", last_start, 1'b1);
        cycle(1'b1, 1'b0, 8'hC7, 1'b0);
        chk("t4_good", good_cnt, 16'd4);
        chk("t4_sat_good", s_good, 2'd3);

        // stray bytes in IDLE
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 8'h55, 1'b0);
            chk("t5_ready", last_ready, 1'b1);
            chk("t5_push", last_push, 1'b0);
        end
        chk("t5_good", good_cnt, 16'd4);
        chk("t5_bad", bad_cnt, 16'd2);

        // randomized traffic
        trunc_prev = 1'b0;
        for (int p = 0; p < 300; p++) begin
            if (!trunc_prev && $urandom_range(0, 4) == 0) begin
                ng = $urandom_range(1, 2);
                for (int g = 0; g < ng; g++) send(1'b0, 8'($urandom));
            end
            ln  = ($urandom_range(0, 19) == 0) ? 63 : $urandom_range(0, 10);
            dst = 2'($urandom_range(0, 3));
            hdr = {dst, 6'(ln)};
            pk.delete();
            pk.push_back(hdr);
            for (int i = 0; i < ln; i++) pk.push_back(8'($urandom));
            crc = crc_of(pk);
            if ($urandom_range(0, 3) == 0) crc = crc ^ 8'($urandom_range(1, 255));
            pk.push_back(crc);
            keep = pk.size();
            trunc_prev = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                keep = $urandom_range(1, pk.size() - 1);
                trunc_prev = 1'b1;
            end
            for (int i = 0; i < keep; i++) send(i == 0, pk[i]);
        end
        if (trunc_prev) begin
            send(1'b1, 8'h40);
            send(1'b0, 8'hC7);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // reset in the middle of a payload
        cycle(1'b1, 1'b1, 8'h05, 1'b0);
        cycle(1'b1, 1'b0, 8'h11, 1'b0);
        cycle(1'b1, 1'b0, 8'h22, 1'b0);
        do_reset();
        chk("t6_done", pkt_done, 1'b0);
        chk("t6_ok", pkt_ok, 1'b0);
        chk("t6_dest", pkt_dest, 2'd0);
        chk("t6_good", good_cnt, 16'd0);
        chk("t6_bad", bad_cnt, 16'd0);
        chk("t6_push", fifo_push, 1'b0);
        chk("t6_flush", fifo_flush, 1'b0);
        cycle(1'b1, 1'b1, 8'h01, 1'b0);
        chk("t6_idle_start", last_start, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h15, 1'b0);
        chk("t6_good_after", good_cnt, 16'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
